// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_pkg
// Description : Shared types, defaults and helpers for the exhaustive
//               truth-table sweep / response-capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_sweep_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    // Default signature configuration (CRC-16 style polynomial)
    localparam int          SIG_W_DEF    = 16;
    localparam logic [15:0] SIG_POLY_DEF = 16'h8005;

    // Number of exhaustive input patterns for an n-input netlist
    function automatic int npat(input int n);
        return 1 << n;
    endfunction

endpackage : tt_sweep_pkg
`default_nettype wire

// File: rtl/tt_sweep_capture_sig_misr.sv
`default_nettype none
// ============================================================================
// Module      : sig_misr
// Description : Single-bit-input Galois MISR. Each enabled cycle shifts the
//               signature left, folds the polynomial in when the MSB falls
//               out, and XORs the new response bit into bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sig_misr
    import tt_sweep_pkg::*;
#(
    parameter int               SIG_W    = SIG_W_DEF,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    // Next signature: clear wins over compaction
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                  ^ {{(SIG_W-1){1'b0}}, din};
        end
    end

    // Signature register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule : sig_misr
`default_nettype wire

// File: rtl/tt_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_capture
// Description : Drives every input pattern of a small combinational netlist
//               in ascending order, holds each for SETTLE+1 cycles, samples
//               the single output into a truth table, compacts the responses
//               into a MISR signature and flags a difference against an
//               expected table latched at start.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int               N_IN     = 2,
    parameter int               SETTLE   = 0,
    parameter int               SIG_W    = SIG_W_DEF,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEF)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [npat(N_IN)-1:0]   exp_tt,
    output logic [N_IN-1:0]         dut_in,
    input  logic                    dut_out,
    output logic                    busy,
    output logic                    done,
    output logic [npat(N_IN)-1:0]   tt,
    output logic [SIG_W-1:0]        sig,
    output logic                    mismatch
);

    localparam int               NPAT     = npat(N_IN);
    localparam int               WCW      = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [WCW-1:0]   SETTLE_W = WCW'(SETTLE);
    localparam logic [N_IN-1:0]  CNT_LAST = {N_IN{1'b1}};

    sweep_state_t      state_q, state_d;
    logic [N_IN-1:0]   cnt_q, cnt_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [NPAT-1:0]   tt_q, tt_d;
    logic [NPAT-1:0]   exp_q, exp_d;
    logic              mismatch_q, mismatch_d;
    logic              misr_clr;
    logic              misr_en;

    // Next-state, counter, capture and compare logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        tt_d       = tt_q;
        exp_d      = exp_q;
        mismatch_d = mismatch_q;
        misr_clr   = 1'b0;
        misr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tt_d       = '0;
                    mismatch_d = 1'b0;
                    exp_d      = exp_tt;
                    cnt_d      = '0;
                    wcnt_d     = '0;
                    misr_clr   = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q < SETTLE_W) begin
                    wcnt_d = wcnt_q + WCW'(1);
                end else begin
                    // Last edge of the hold window: capture the response
                    tt_d[cnt_q] = dut_out;
                    misr_en     = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // Compare against the table including this final sample
                        mismatch_d = (tt_d != exp_q);
                        state_d    = DONE;
                    end else begin
                        cnt_d  = cnt_q + N_IN'(1);
                        wcnt_d = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and captured results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            tt_q       <= '0;
            exp_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            tt_q       <= tt_d;
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
        end
    end

    sig_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (misr_clr),
        .en  (misr_en),
        .din (dut_out),
        .sig (sig)
    );

    // Outputs decode straight from registered state so they are glitch-free
    assign dut_in   = (state_q == WAIT) ? cnt_q : '0;
    assign busy     = (state_q == WAIT);
    assign done     = (state_q == DONE);
    assign tt       = tt_q;
    assign mismatch = mismatch_q;

endmodule : tt_sweep_capture
`default_nettype wire

// File: tb/tb_tt_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_sweep_capture
// Description : Directed self-checking bench for tt_sweep_capture. Two
//               instances (SETTLE=0 and SETTLE=2) each drive a behavioural
//               AND/XOR gate selected by the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_sweep_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start2;
    logic [3:0]  exp0, exp2;
    logic        xor0, xor2;

    logic [1:0]  din0, din2;
    logic        dout0, dout2;
    logic        busy0, busy2, done0, done2, mis0, mis2;
    logic [3:0]  tt0, tt2;
    logic [15:0] sig0, sig2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Benchmark netlists: 2-input AND or XOR
    assign dout0 = xor0 ? (din0[0] ^ din0[1]) : (din0[0] & din0[1]);
    assign dout2 = xor2 ? (din2[0] ^ din2[1]) : (din2[0] & din2[1]);

    tt_sweep_capture #(.N_IN(2), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .exp_tt(exp0),
        .dut_in(din0), .dut_out(dout0), .busy(busy0), .done(done0),
        .tt(tt0), .sig(sig0), .mismatch(mis0)
    );

    tt_sweep_capture #(.N_IN(2), .SETTLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .exp_tt(exp2),
        .dut_in(din2), .dut_out(dout2), .busy(busy2), .done(done2),
        .tt(tt2), .sig(sig2), .mismatch(mis2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start2 = 1'b0;
        exp0 = 4'b0; exp2 = 4'b0; xor0 = 1'b0; xor2 = 1'b0;
        cyc(); cyc();

        // Reset state
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_din",  32'(din0),  32'd0);
        chk("rst_tt",   32'(tt0),   32'd0);
        chk("rst_sig",  32'(sig0),  32'd0);
        chk("rst_mis",  32'(mis0),  32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        rst = 1'b0;
        cyc();

        // AND sweep, start pulse
        exp0 = 4'b1000; start0 = 1'b1;
        cyc();                                  // cycle 1
        start0 = 1'b0;
        chk("and_din0",  32'(din0),  32'd0);
        chk("and_busy1", 32'(busy0), 32'd1);
        for (int p = 1; p < 4; p++) begin
            cyc();
            chk("and_din_seq", 32'(din0), 32'(p));
            chk("and_nodone",  32'(done0), 32'd0);
        end
        cyc();                                  // cycle 5
        chk("and_done",  32'(done0), 32'd1);
        chk("and_busy5", 32'(busy0), 32'd0);
        chk("and_din5",  32'(din0),  32'd0);
        chk("and_tt",    32'(tt0),   32'h8);
        chk("and_sig",   32'(sig0),  32'h0001);
        chk("and_mis",   32'(mis0),  32'd0);
        cyc();
        chk("and_done_pulse", 32'(done0), 32'd0);
        chk("and_tt_hold",    32'(tt0),   32'h8);

        // XOR sweep with start held high throughout
        xor0 = 1'b1; exp0 = 4'b0110; start0 = 1'b1;
        cyc();                                  // cycle 1
        chk("xor_din0", 32'(din0), 32'd0);
        for (int p = 1; p < 4; p++) begin
            cyc();
            chk("xor_din_seq", 32'(din0), 32'(p));
        end
        cyc();                                  // cycle 5
        chk("xor_done", 32'(done0), 32'd1);
        chk("xor_tt",   32'(tt0),   32'h6);
        chk("xor_sig",  32'(sig0),  32'h0006);
        chk("xor_mis",  32'(mis0),  32'd0);
        cyc();                                  // cycle 6: back in IDLE
        chk("hold_idle_busy", 32'(busy0), 32'd0);
        chk("hold_idle_done", 32'(done0), 32'd0);
        cyc();                                  // cycle 7: second sweep begins
        start0 = 1'b0;
        chk("hold_restart_busy", 32'(busy0), 32'd1);
        chk("hold_restart_din",  32'(din0),  32'd0);
        cyc(); cyc(); cyc();
        cyc();                                  // cycle 11
        chk("hold_second_done", 32'(done0), 32'd1);
        cyc();

        // XOR sweep against a wrong expected table
        exp0 = 4'b1000; start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        cyc(); cyc(); cyc();
        cyc();
        chk("mis_done", 32'(done0), 32'd1);
        chk("mis_tt",   32'(tt0),   32'h6);
        chk("mis_flag", 32'(mis0),  32'd1);
        cyc();
        chk("mis_held1", 32'(mis0), 32'd1);
        cyc();
        chk("mis_held2", 32'(mis0), 32'd1);
        exp0 = 4'b0110; start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        chk("mis_cleared", 32'(mis0), 32'd0);
        cyc(); cyc(); cyc();
        cyc();
        chk("mis_ok_done", 32'(done0), 32'd1);
        chk("mis_ok_flag", 32'(mis0),  32'd0);
        cyc();

        // Reset during pattern 2 of an XOR sweep
        start0 = 1'b1;
        cyc();                                  // cycle 1, pattern 0
        start0 = 1'b0;
        cyc();                                  // pattern 1
        cyc();                                  // pattern 2
        chk("abort_pre_din", 32'(din0), 32'd2);
        chk("abort_pre_tt",  32'(tt0),  32'h2);
        chk("abort_pre_sig", 32'(sig0), 32'h0001);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_din",  32'(din0),  32'd0);
        chk("abort_tt",   32'(tt0),   32'd0);
        chk("abort_sig",  32'(sig0),  32'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("abort_nodone", 32'(done0), 32'd0);
        end

        // Reset and start asserted together
        rst = 1'b1; start0 = 1'b1;
        cyc();
        chk("rst_start_busy", 32'(busy0), 32'd0);
        chk("rst_start_din",  32'(din0),  32'd0);
        rst = 1'b0; start0 = 1'b0;
        cyc();
        chk("rst_start_idle", 32'(busy0), 32'd0);

        // SETTLE=2 AND sweep: each pattern held three cycles
        exp2 = 4'b1000; xor2 = 1'b0; start2 = 1'b1;
        cyc();                                  // cycle 1
        start2 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            chk("s2_din",  32'(din2),  32'((i - 1) / 3));
            chk("s2_busy", 32'(busy2), 32'd1);
            if (i < 12) cyc();
        end
        cyc();                                  // cycle 13
        chk("s2_done", 32'(done2), 32'd1);
        chk("s2_tt",   32'(tt2),   32'h8);
        chk("s2_sig",  32'(sig2),  32'h0001);
        chk("s2_mis",  32'(mis2),  32'd0);
        cyc();
        chk("s2_done_pulse", 32'(done2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_tt_sweep_capture
`default_nettype wire
